// File: rtl/pipe_alu.sv
// Two-stage pipelined ALU: S1 registers operands, S2 registers result/flags/leading-one index.
// Define PIPE_ALU_SAT_EN to saturate ADD/SUB results on signed overflow.
module pipe_alu #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [2:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic                     out_c,
    output logic                     out_v,
    output logic                     out_n,
    output logic                     out_z,
    output logic [$clog2(WIDTH)-1:0] out_msb_idx,
    output logic                     out_msb_vld,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_NOR, OP_NAND, OP_XNOR
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op_e              op;
        logic [TAG_W-1:0] tag;
    } s1_t;

    logic [2:1]       vld_pipe;
    s1_t              s1_q;
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] y_d;
    logic             c_d;
    logic             v_d;
    logic [IDX_W-1:0] idx_d;
    logic             mvld_d;

    // Whole pipe moves together; a stalled output freezes both stages.
    assign adv       = !vld_pipe[2] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[2];

    always_comb begin
        b_eff = (s1_q.op == OP_SUB) ? ~s1_q.b : s1_q.b;
        sum   = {1'b0, s1_q.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (s1_q.op == OP_SUB)};
        y_d   = sum[WIDTH-1:0];
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (s1_q.op)
            OP_ADD, OP_SUB: begin
                c_d = sum[WIDTH];
                v_d = (s1_q.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_q.a[WIDTH-1]);
`ifdef PIPE_ALU_SAT_EN
                // Overflow direction follows the sign of A.
                if (v_d)
                    y_d = s1_q.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
            OP_XOR:  y_d = s1_q.a ^ s1_q.b;
            OP_OR:   y_d = s1_q.a | s1_q.b;
            OP_AND:  y_d = s1_q.a & s1_q.b;
            OP_NOR:  y_d = ~(s1_q.a | s1_q.b);
            OP_NAND: y_d = ~(s1_q.a & s1_q.b);
            OP_XNOR: y_d = ~(s1_q.a ^ s1_q.b);
            default: y_d = sum[WIDTH-1:0];
        endcase
    end

    // Ascending scan so the highest set bit wins.
    always_comb begin
        idx_d  = '0;
        mvld_d = |y_d;
        for (int i = 0; i < WIDTH; i++)
            if (y_d[i]) idx_d = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe    <= '0;
            s1_q        <= '0;
            out_y       <= '0;
            out_c       <= 1'b0;
            out_v       <= 1'b0;
            out_n       <= 1'b0;
            out_z       <= 1'b0;
            out_msb_idx <= '0;
            out_msb_vld <= 1'b0;
            out_tag     <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[1], in_valid};
            if (in_valid) begin
                s1_q.a   <= in_a;
                s1_q.b   <= in_b;
                s1_q.op  <= op_e'(in_op);
                s1_q.tag <= in_tag;
            end
            if (vld_pipe[1]) begin
                out_y       <= y_d;
                out_c       <= c_d;
                out_v       <= v_d;
                out_n       <= y_d[WIDTH-1];
                out_z       <= ~mvld_d;
                out_msb_idx <= idx_d;
                out_msb_vld <= mvld_d;
                out_tag     <= s1_q.tag;
            end
        end
    end
endmodule
